// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prbs_pkg
// Description : Shared PRBS definitions: LFSR taps, next-word function, checker
//               state encoding and counter width.
// Revision    : 1.0
// ============================================================================
package prbs_pkg;

    localparam int CNT_W  = 32;
    localparam int LFSR_W = 32;

    // Tap masks: tap k of the polynomial maps to bit k-1
    localparam logic [31:0] TAPS_14 = 32'h0000_2015;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    function automatic logic [31:0] prbs_taps(input int n);
        case (n)
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return TAPS_14;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            32:      return 32'h8020_0003;
            default: return (32'd1 << (n - 1)) | (32'd1 << (n - 2));
        endcase
    endfunction

    // Fibonacci LFSR step: shift left, feedback XOR of tapped bits into the LSB
    function automatic logic [31:0] prbs_next(input logic [31:0] cur, input int n);
        logic [31:0] mask;
        mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        return ((cur << 1) | {31'd0, ^(cur & prbs_taps(n))}) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : prbs_sat_cnt
// Description : Saturating up-counter with synchronous clear (clear has
//               priority) and a variable increment amount.
// Revision    : 1.0
// ============================================================================
module prbs_sat_cnt #(
    parameter int W     = 32,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    input  logic [INC_W-1:0] amt,
    output logic [W-1:0]     count
);

    localparam int SUM_W = W + 1;

    logic [W-1:0] count_q, count_d;
    logic [W:0]   sum;

    always_comb begin
        sum     = {1'b0, count_q} + SUM_W'(amt);
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = sum[W] ? '1 : sum[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/prbs_checker.sv
`default_nettype none
// ============================================================================
// Module      : prbs_checker
// Description : PRBS stream checker with SEARCH/LOCKED acquisition and
//               saturating error/word counters. Define PRBS_CHK_BITERR_EN to
//               add the biterr_cnt output.
// Revision    : 1.0
// ============================================================================
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int N        = 14,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     din,
    input  logic             din_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt
`ifdef PRBS_CHK_BITERR_EN
    ,
    output logic [CNT_W-1:0] biterr_cnt
`endif
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W  = $clog2(LOSS_CNT + 1);

    state_e              state_q, state_d;
    logic                first_q, first_d;
    logic [LFSR_W-1:0]   prev_q, prev_d;
    logic [LFSR_W-1:0]   exp_q, exp_d;
    logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
    logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic                locked_q, locked_d;
    logic                err_pulse_q, err_pulse_d;
    logic                word_inc, err_inc;

    // Words are held zero-extended so the shared 32-bit LFSR function applies directly
    logic [LFSR_W-1:0]   din_ext, prev_next, exp_next, din_next;

    assign din_ext   = LFSR_W'(din);
    assign prev_next = prbs_next(prev_q, N);
    assign exp_next  = prbs_next(exp_q, N);
    assign din_next  = prbs_next(din_ext, N);

    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        prev_d      = prev_q;
        exp_d       = exp_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_pulse_d = 1'b0;
        word_inc    = 1'b0;
        err_inc     = 1'b0;
        if (din_valid) begin
            case (state_q)
                SEARCH: begin
                    prev_d  = din_ext;
                    first_d = 1'b0;
                    if (!first_q && (din_ext == prev_next) && (din_ext != '0)) begin
                        if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d     = LOCKED;
                            exp_d       = din_next;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + MATCH_W'(1);
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-running expectation keeps a corrupted word from poisoning later ones
                    word_inc = 1'b1;
                    exp_d    = exp_next;
                    if (din_ext != exp_q) begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        if (miss_cnt_q == MISS_W'(LOSS_CNT - 1)) begin
                            state_d    = SEARCH;
                            first_d    = 1'b1;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MISS_W'(1);
                        end
                    end else begin
                        miss_cnt_d = '0;
                    end
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            first_q     <= 1'b1;
            prev_q      <= '0;
            exp_q       <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            prev_q      <= prev_d;
            exp_q       <= exp_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

    prbs_sat_cnt #(.W(CNT_W), .INC_W(1)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (err_inc),
        .amt   (1'b1),
        .count (err_cnt)
    );

    prbs_sat_cnt #(.W(CNT_W), .INC_W(1)) u_word_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (word_inc),
        .amt   (1'b1),
        .count (word_cnt)
    );

`ifdef PRBS_CHK_BITERR_EN
    logic [5:0] biterr_amt;

    always_comb begin
        biterr_amt = '0;
        for (int i = 0; i < LFSR_W; i++) begin
            biterr_amt = biterr_amt + 6'(din_ext[i] ^ exp_q[i]);
        end
    end

    prbs_sat_cnt #(.W(CNT_W), .INC_W(6)) u_biterr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .inc   (err_inc),
        .amt   (biterr_amt),
        .count (biterr_cnt)
    );
`endif

endmodule
`default_nettype wire

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter N, default 14, PRBS word width in bits; legal range 4..32.
REQ-002 Parameter LOCK_CNT, default 4, consecutive matching words required to declare lock.
REQ-003 Parameter LOSS_CNT, default 3, consecutive mismatching words required to declare loss of lock.
REQ-004 clk  input  1  single clock; all state SHALL be updated on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 din  input  N  PRBS word consumed from the upstream prbs generator's rnd_bus output.
REQ-007 din_valid  input  1  high when din carries a new word; words are sampled on clock edges where it is high.
REQ-008 clear  input  1  synchronous clear of both counters; lock state is not affected.
REQ-009 locked  output  1  checker is in LOCKED state.
REQ-010 err_pulse  output  1  one-cycle pulse for each mismatching word while locked.
REQ-011 err_cnt  output  32  saturating count of mismatching words while locked.
REQ-012 word_cnt  output  32  saturating count of words checked while locked.

Function
REQ-013 Next-word function SHALL be the shared package function prbs_next: a Fibonacci LFSR that shifts left by one, with new LSB = din[N-1] ^ din[4] ^ din[2] ^ din[0] for N=14 (taps 14,5,3,1), bit-identical to the generator.
REQ-014 FSM states are SEARCH and LOCKED; the reset state is SEARCH.
REQ-015 SEARCH matching: a valid word is a match when it equals prbs_next(previous valid word) and is non-zero.
REQ-016 SEARCH match counting: each match increments match_cnt; a mismatch or an all-zero word resets match_cnt to 0.
REQ-017 The first valid word after reset or after re-entering SEARCH only loads the previous-word register and is never a match.
REQ-018 SEARCH SHALL transition to LOCKED on the valid word that brings match_cnt to LOCK_CNT; expected register <= prbs_next(din).
REQ-019 In LOCKED, each valid word SHALL be compared to the expected register, not to din, so that errors do not propagate.
REQ-020 In LOCKED, expected advances to prbs_next(expected) on every valid word, whether the word matches or not.
REQ-021 In LOCKED, a mismatch SHALL assert err_pulse, increment err_cnt, and increment miss_cnt; a match clears miss_cnt.
REQ-022 In LOCKED, word_cnt SHALL increment on every valid word.
REQ-023 When miss_cnt reaches LOSS_CNT, the FSM SHALL return to SEARCH on that same edge; err_cnt is counted for that word.
REQ-024 locked and err_pulse SHALL be registered, with 1-cycle latency from the sampling edge of the causing word.
REQ-025 err_cnt and word_cnt SHALL saturate at 32'hFFFF_FFFF with no wrap.
REQ-026 clear and a counting event on the same edge: clear wins and the counter becomes 0; err_pulse still fires.
REQ-027 din_valid low: no state, counter, or output change except that err_pulse returns to 0.

Reset
REQ-028 On rst_n low, asynchronously: state=SEARCH, locked=0, err_pulse=0, err_cnt=0, word_cnt=0, match_cnt=0, miss_cnt=0, previous/expected registers=0, first-word flag set.
REQ-029 Reset asserted mid-stream SHALL abort lock immediately; after release, reacquisition takes LOCK_CNT+1 valid words.

Configuration
REQ-030 Macro PRBS_CHK_BITERR_EN defined: an extra output biterr_cnt[31:0] SHALL add popcount(din ^ expected) per locked valid word, saturating and cleared by clear/reset.
REQ-031 Macro PRBS_CHK_BITERR_EN undefined: the port and its logic SHALL be absent, and all other behaviour is identical.

Structure
REQ-032 Package prbs_pkg SHALL hold the prbs_next function, tap constants, the state enum (SEARCH, LOCKED), and the counter width constant CNT_W=32; it is shared with prbs.
REQ-033 One sub-module, prbs_sat_cnt (a parameterised saturating counter with clear and increment amount), SHALL be instantiated for err_cnt, word_cnt, and biterr_cnt.

Verification
REQ-034 Clean stream from seed 14'h0001, din_valid=1 continuously -> locked rises 1 cycle after word 5 (LOCK_CNT+1); err_cnt=0 after 100 words, word_cnt=95.
REQ-035 While locked, flip bit 0 of a single word -> exactly one err_pulse, err_cnt=1, locked stays 1, and the following words match.
REQ-036 While locked, corrupt 3 consecutive words -> err_cnt=3, locked falls after the 3rd; clean stream resumes -> relock after 5 words.
REQ-037 All-zero din held for 20 valid cycles -> locked never asserts, and the counters stay 0.
REQ-038 Toggle din_valid 1/0 on alternate cycles with a clean stream -> lock after 5 valid words, no errors; pulse rst_n low for 10 ns while locked -> locked=0 immediately and counters are 0.
REQ-039 Assert clear on the same edge as a mismatch -> err_pulse=1 and err_cnt=0; with PRBS_CHK_BITERR_EN defined, a word with 3 bits flipped -> biterr_cnt=3.
